datapath_seq: RTL and testbench



---
 rtl/datapath_seq_if.sv | 63 ++++++
 rtl/datapath_seq.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_datapath_seq.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_seq_if
//  Description : Command and datapath-control bundle for datapath_seq.
//                master : command source / datapath side
//                         (drives the command, observes the controls)
//                slave  : the sequencer
//                         (receives the command, drives the controls)
//  Signals     : start, opcode, rd, rn, rm, sh, imm          command in
//                readnum, writenum, write, vsel, loada, loadb,
//                asel, bsel, loadc, loads, shift, ALUop,
//                datapath_in                                  datapath ctrl
//                busy, done, err, op_count                    status
//  Revision    : 1.0  initial release
// ============================================================================
interface datapath_seq_if #(
    parameter int W = 16
);
    // Command
    logic           start;
    logic [2:0]     opcode;
    logic [2:0]     rd;
    logic [2:0]     rn;
    logic [2:0]     rm;
    logic [1:0]     sh;
    logic [W-1:0]   imm;

    // Datapath controls
    logic [2:0]     readnum;
    logic [2:0]     writenum;
    logic           write;
    logic           vsel;
    logic           loada;
    logic           loadb;
    logic           asel;
    logic           bsel;
    logic           loadc;
    logic           loads;
    logic [1:0]     shift;
    logic [1:0]     ALUop;
    logic [W-1:0]   datapath_in;

    // Status
    logic           busy;
    logic           done;
    logic           err;
    logic [15:0]    op_count;

    modport master (
        output start, opcode, rd, rn, rm, sh, imm,
        input  readnum, writenum, write, vsel, loada, loadb, asel, bsel,
               loadc, loads, shift, ALUop, datapath_in,
               busy, done, err, op_count
    );

    modport slave (
        input  start, opcode, rd, rn, rm, sh, imm,
        output readnum, writenum, write, vsel, loada, loadb, asel, bsel,
               loadc, loads, shift, ALUop, datapath_in,
               busy, done, err, op_count
    );
endinterface
`default_nettype wire

// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_seq
//  Description : Multi-cycle sequencer for the register-file / shifter / ALU
//                datapath. One command is latched per start pulse in IDLE and
//                walked through LOADA / LOADB / EXEC / WB as the opcode needs,
//                finishing with a one-cycle done (and err for illegal ops).
//  Ports       : clk    rising-edge clock
//                reset  synchronous active-high reset
//                bus    datapath_seq_if.slave (command in, controls out)
//  Options     : DATAPATH_SEQ_OPCOUNT_EN - when defined, op_count counts
//                completed legal commands (saturating); otherwise it reads 0
//                and no counter is built.
//  Revision    : 1.0  initial release
// ============================================================================
module datapath_seq #(
    parameter int W = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    datapath_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADA = 3'd1,
        S_LOADB = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [2:0] c_OP_MOVI = 3'd0;
    localparam logic [2:0] c_OP_MOV  = 3'd1;
    localparam logic [2:0] c_OP_ADD  = 3'd2;
    localparam logic [2:0] c_OP_CMP  = 3'd3;
    localparam logic [2:0] c_OP_AND  = 3'd4;
    localparam logic [2:0] c_OP_MVN  = 3'd5;

    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_SUB = 2'b01;
    localparam logic [1:0] c_ALU_AND = 2'b10;
    localparam logic [1:0] c_ALU_NOT = 2'b11;

    // ------------------------------------------------------------------
    // State and latched command
    // ------------------------------------------------------------------
    state_t         r_state;
    logic [2:0]     r_opcode;
    logic [2:0]     r_rd;
    logic [2:0]     r_rn;
    logic [2:0]     r_rm;
    logic [1:0]     r_sh;
    logic [W-1:0]   r_imm;

    // Registered outputs
    logic [2:0]     r_readnum;
    logic [2:0]     r_writenum;
    logic           r_write;
    logic           r_vsel;
    logic           r_loada;
    logic           r_loadb;
    logic           r_asel;
    logic           r_bsel;
    logic           r_loadc;
    logic           r_loads;
    logic [1:0]     r_shift;
    logic [1:0]     r_aluop;
    logic [W-1:0]   r_dp_in;
    logic           r_busy;
    logic           r_done;
    logic           r_err;

    // Next-cycle values
    state_t         w_next_state;
    logic           w_take;
    logic [2:0]     w_opcode;
    logic [2:0]     w_rd;
    logic [2:0]     w_rn;
    logic [2:0]     w_rm;
    logic [1:0]     w_sh;
    logic [W-1:0]   w_imm;
    logic           w_legal;

    logic [2:0]     w_readnum;
    logic [2:0]     w_writenum;
    logic           w_write;
    logic           w_vsel;
    logic           w_loada;
    logic           w_loadb;
    logic           w_asel;
    logic           w_bsel;
    logic           w_loadc;
    logic           w_loads;
    logic [1:0]     w_shift;
    logic [1:0]     w_aluop;
    logic [W-1:0]   w_dp_in;
    logic           w_busy;
    logic           w_done;
    logic           w_err;

    // ------------------------------------------------------------------
    // Command capture: fields are only taken in IDLE with start high; at
    // all other times the latched copy is held so the inputs may change.
    // ------------------------------------------------------------------
    always_comb begin
        w_take   = (r_state == S_IDLE) && bus.start;
        w_opcode = w_take ? bus.opcode : r_opcode;
        w_rd     = w_take ? bus.rd     : r_rd;
        w_rn     = w_take ? bus.rn     : r_rn;
        w_rm     = w_take ? bus.rm     : r_rm;
        w_sh     = w_take ? bus.sh     : r_sh;
        w_imm    = w_take ? bus.imm    : r_imm;
        w_legal  = (w_opcode <= c_OP_MVN);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.opcode)
                        c_OP_MOVI:                     w_next_state = S_WB;
                        c_OP_MOV, c_OP_MVN:            w_next_state = S_LOADB;
                        c_OP_ADD, c_OP_CMP, c_OP_AND:  w_next_state = S_LOADA;
                        default:                       w_next_state = S_DONE;
                    endcase
                end
            end
            S_LOADA: w_next_state = S_LOADB;
            S_LOADB: w_next_state = S_EXEC;
            // CMP only updates status, so it has nothing to write back.
            S_EXEC:  w_next_state = (r_opcode == c_OP_CMP) ? S_DONE : S_WB;
            S_WB:    w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode for the state being entered. The result is registered,
    // so the outputs of a state appear together with that state and never
    // depend combinationally on the command inputs.
    // ------------------------------------------------------------------
    always_comb begin
        w_readnum  = 3'd0;
        w_writenum = 3'd0;
        w_write    = 1'b0;
        w_vsel     = 1'b0;
        w_loada    = 1'b0;
        w_loadb    = 1'b0;
        w_asel     = 1'b0;
        w_bsel     = 1'b0;
        w_loadc    = 1'b0;
        w_loads    = 1'b0;
        w_shift    = 2'b00;
        w_aluop    = 2'b00;
        w_dp_in    = '0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_busy     = (w_next_state != S_IDLE);

        case (w_next_state)
            S_LOADA: begin
                w_readnum = w_rn;
                w_loada   = 1'b1;
            end
            S_LOADB: begin
                w_readnum = w_rm;
                w_loadb   = 1'b1;
            end
            S_EXEC: begin
                w_shift = w_sh;
                w_loads = 1'b1;
                case (w_opcode)
                    c_OP_MOV: begin
                        // A is forced to zero so the ALU passes shifted B.
                        w_asel  = 1'b1;
                        w_aluop = c_ALU_ADD;
                        w_loadc = 1'b1;
                    end
                    c_OP_MVN: begin
                        w_aluop = c_ALU_NOT;
                        w_loadc = 1'b1;
                    end
                    c_OP_ADD: begin
                        w_aluop = c_ALU_ADD;
                        w_loadc = 1'b1;
                    end
                    c_OP_AND: begin
                        w_aluop = c_ALU_AND;
                        w_loadc = 1'b1;
                    end
                    c_OP_CMP: begin
                        w_aluop = c_ALU_SUB;
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                w_writenum = w_rd;
                w_write    = 1'b1;
                if (w_opcode == c_OP_MOVI) begin
                    w_vsel  = 1'b1;
                    w_dp_in = w_imm;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_err  = !w_legal;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer registers
    // ------------------------------------------------------------------
`ifdef DATAPATH_SEQ_OPCOUNT_EN
    logic [15:0] r_op_count;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_opcode   <= 3'd0;
            r_rd       <= 3'd0;
            r_rn       <= 3'd0;
            r_rm       <= 3'd0;
            r_sh       <= 2'b00;
            r_imm      <= '0;
            r_readnum  <= 3'd0;
            r_writenum <= 3'd0;
            r_write    <= 1'b0;
            r_vsel     <= 1'b0;
            r_loada    <= 1'b0;
            r_loadb    <= 1'b0;
            r_asel     <= 1'b0;
            r_bsel     <= 1'b0;
            r_loadc    <= 1'b0;
            r_loads    <= 1'b0;
            r_shift    <= 2'b00;
            r_aluop    <= 2'b00;
            r_dp_in    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef DATAPATH_SEQ_OPCOUNT_EN
            r_op_count <= 16'h0000;
`endif
        end else begin
            r_state    <= w_next_state;
            r_opcode   <= w_opcode;
            r_rd       <= w_rd;
            r_rn       <= w_rn;
            r_rm       <= w_rm;
            r_sh       <= w_sh;
            r_imm      <= w_imm;
            r_readnum  <= w_readnum;
            r_writenum <= w_writenum;
            r_write    <= w_write;
            r_vsel     <= w_vsel;
            r_loada    <= w_loada;
            r_loadb    <= w_loadb;
            r_asel     <= w_asel;
            r_bsel     <= w_bsel;
            r_loadc    <= w_loadc;
            r_loads    <= w_loads;
            r_shift    <= w_shift;
            r_aluop    <= w_aluop;
            r_dp_in    <= w_dp_in;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
`ifdef DATAPATH_SEQ_OPCOUNT_EN
            // Count on leaving DONE for legal commands, stick at all-ones.
            if ((r_state == S_DONE) && (r_opcode <= c_OP_MVN) &&
                (r_op_count != 16'hFFFF)) begin
                r_op_count <= r_op_count + 16'd1;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign bus.readnum     = r_readnum;
    assign bus.writenum    = r_writenum;
    assign bus.write       = r_write;
    assign bus.vsel        = r_vsel;
    assign bus.loada       = r_loada;
    assign bus.loadb       = r_loadb;
    assign bus.asel        = r_asel;
    assign bus.bsel        = r_bsel;
    assign bus.loadc       = r_loadc;
    assign bus.loads       = r_loads;
    assign bus.shift       = r_shift;
    assign bus.ALUop       = r_aluop;
    assign bus.datapath_in = r_dp_in;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
`ifdef DATAPATH_SEQ_OPCOUNT_EN
    assign bus.op_count    = r_op_count;
`else
    assign bus.op_count    = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_datapath_seq
//  Description : Self-checking bench for datapath_seq. A small register-file /
//                shifter / ALU model is driven by the sequencer's controls; a
//                scoreboard holds each issued command and its due cycle, and a
//                monitor checks timing, control pulses and architectural
//                results against a plain arithmetic reference on every done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_datapath_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    datapath_seq_if #(.W(W)) bus ();

    datapath_seq #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Datapath model driven by the sequencer (held while reset is high)
    // ------------------------------------------------------------------
    logic [W-1:0] R [8];
    logic [W-1:0] A, B, C, ain, bin, sout, alu;
    logic         Z;

    always_comb begin
        case (bus.shift)
            2'b00:   sout = B;
            2'b01:   sout = {B[W-2:0], 1'b0};
            2'b10:   sout = {1'b0, B[W-1:1]};
            default: sout = {B[W-1], B[W-1:1]};
        endcase
        ain = bus.asel ? '0 : A;
        bin = bus.bsel ? W'(bus.datapath_in[4:0]) : sout;
        case (bus.ALUop)
            2'b00:   alu = ain + bin;
            2'b01:   alu = ain - bin;
            2'b10:   alu = ain & bin;
            default: alu = ~bin;
        endcase
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (bus.write) R[bus.writenum] <= bus.vsel ? bus.datapath_in : C;
            if (bus.loada) A <= R[bus.readnum];
            if (bus.loadb) B <= R[bus.readnum];
            if (bus.loadc) C <= alu;
            if (bus.loads) Z <= (alu == '0);
        end
    end

    // ------------------------------------------------------------------
    // Reference model (command-level arithmetic)
    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0]   op;
        logic [2:0]   rd;
        logic [2:0]   rn;
        logic [2:0]   rm;
        logic [1:0]   sh;
        logic [W-1:0] imm;
        int           due;
    } cmd_t;

    cmd_t q[$];

    function automatic int latency(input logic [2:0] op);
        case (op)
            3'd0:          return 2;
            3'd1,3'd3,3'd5: return 4;
            3'd2,3'd4:     return 5;
            default:       return 1;
        endcase
    endfunction

    // Expected pulse counts per command, one nibble each: write,loada,loadb,loadc,loads
    function automatic logic [19:0] pulses_for(input logic [2:0] op);
        case (op)
            3'd0:      return 20'h10000;
            3'd1,3'd5: return 20'h10111;
            3'd2,3'd4: return 20'h11111;
            3'd3:      return 20'h01101;
            default:   return 20'h00000;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input logic [1:0] s);
        case (s)
            2'b00:   return v;
            2'b01:   return W'(v * 2);
            2'b10:   return v / 2;
            default: return (v / 2) | (v & (W'(1) << (W-1)));
        endcase
    endfunction

    logic [W-1:0] ref_R [8];
    logic         ref_Z;
    int           ref_cnt;

    // ------------------------------------------------------------------
    // Monitor: samples 1ns after each rising edge
    // ------------------------------------------------------------------
    initial begin : monitor
        logic [3:0]   pw, pa, pb, pc, ps;
        logic         prev_done;
        logic [W-1:0] b;
        logic [W-1:0] res;
        cmd_t         e;
        for (int i = 0; i < 8; i++) ref_R[i] = '0;
        ref_Z = 1'b0; ref_cnt = 0;
        pw = 0; pa = 0; pb = 0; pc = 0; ps = 0; prev_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                check("reset_outputs",
                      32'({bus.busy, bus.done, bus.err, bus.write, bus.vsel, bus.loada,
                           bus.loadb, bus.asel, bus.bsel, bus.loadc, bus.loads,
                           bus.shift, bus.ALUop, bus.readnum, bus.writenum}), 32'd0);
                check("reset_datapath_in", 32'(bus.datapath_in), 32'd0);
                check("reset_op_count", 32'(bus.op_count), 32'd0);
                pw = 0; pa = 0; pb = 0; pc = 0; ps = 0; prev_done = 1'b0; ref_cnt = 0;
                continue;
            end
            if (prev_done) check("busy_after_done", 32'(bus.busy), 32'd0);
            if (!bus.busy)
                check("idle_controls_quiet",
                      32'({bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.done}), 32'd0);
            if (!(bus.write && bus.vsel)) check("datapath_in_zero", 32'(bus.datapath_in), 32'd0);
            if (bus.err && !bus.done) check("err_without_done", 32'(bus.err), 32'd0);

            pw += 4'(bus.write); pa += 4'(bus.loada); pb += 4'(bus.loadb);
            pc += 4'(bus.loadc); ps += 4'(bus.loads);

            if (bus.done) begin
                if (q.size() == 0) begin
                    check("done_without_command", 32'(bus.done), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.due));
                    check("err", 32'(bus.err), 32'(e.op > 3'd5));
                    check("busy_with_done", 32'(bus.busy), 32'd1);
`ifdef DATAPATH_SEQ_OPCOUNT_EN
                    check("op_count", 32'(bus.op_count), 32'(ref_cnt));
`else
                    check("op_count", 32'(bus.op_count), 32'd0);
`endif
                    check("pulses", 32'({pw, pa, pb, pc, ps}), 32'(pulses_for(e.op)));
                    b = ref_shift(ref_R[e.rm], e.sh);
                    case (e.op)
                        3'd0: ref_R[e.rd] = e.imm;
                        3'd1: begin res = b;                 ref_R[e.rd] = res; ref_Z = (res == '0); end
                        3'd2: begin res = ref_R[e.rn] + b;   ref_R[e.rd] = res; ref_Z = (res == '0); end
                        3'd3: begin res = ref_R[e.rn] - b;   ref_Z = (res == '0); end
                        3'd4: begin res = ref_R[e.rn] & b;   ref_R[e.rd] = res; ref_Z = (res == '0); end
                        3'd5: begin res = ~b;                ref_R[e.rd] = res; ref_Z = (res == '0); end
                        default: ;
                    endcase
                    if (e.op <= 3'd5 && e.op != 3'd3) check("rd_value", 32'(R[e.rd]), 32'(ref_R[e.rd]));
                    if (e.op >= 3'd1 && e.op <= 3'd5) check("Z", 32'(Z), 32'(ref_Z));
                    if (e.op <= 3'd5 && ref_cnt < 65535) ref_cnt++;
                end
                pw = 0; pa = 0; pb = 0; pc = 0; ps = 0;
            end
            prev_done = bus.done;
        end
    end

    // ------------------------------------------------------------------
    // Driver (drives on falling edges)
    // ------------------------------------------------------------------
    task automatic junk_fields();
        bus.opcode = 3'($urandom);
        bus.rd     = 3'($urandom);
        bus.rn     = 3'($urandom);
        bus.rm     = 3'($urandom);
        bus.sh     = 2'($urandom);
        bus.imm    = W'($urandom);
    endtask

    // Called at a falling edge with the DUT in IDLE; returns at the first
    // falling edge back in IDLE. While busy, start and the fields toggle.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic [1:0] sh, input logic [W-1:0] imm);
        int guard;
        cmd_t c;
        bus.start = 1'b1; bus.opcode = op; bus.rd = rd; bus.rn = rn; bus.rm = rm;
        bus.sh = sh; bus.imm = imm;
        c.op = op; c.rd = rd; c.rn = rn; c.rm = rm; c.sh = sh; c.imm = imm;
        c.due = cyc + latency(op);
        q.push_back(c);
        @(negedge clk);
        guard = 0;
        while (bus.busy && guard < 40) begin
            bus.start = 1'($urandom);
            junk_fields();
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) check("command_timeout", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
    endtask

    initial begin : driver
        logic [W-1:0] v;
        reset = 1'b1;
        bus.start = 1'b0; bus.opcode = '0; bus.rd = '0; bus.rn = '0; bus.rm = '0;
        bus.sh = '0; bus.imm = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Fill the register file
        for (int i = 0; i < 8; i++) begin
            v = W'($urandom);
            issue(3'd0, 3'(i), 3'd0, 3'd0, 2'b00, v);
        end

        // Directed sequence
        issue(3'd0, 3'd3, 3'd0, 3'd0, 2'b00, 16'h0042);
        issue(3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 16'd5);
        issue(3'd0, 3'd1, 3'd0, 3'd0, 2'b00, 16'd3);
        issue(3'd2, 3'd2, 3'd0, 3'd1, 2'b01, 16'h0000);
        check("R2_after_add", 32'(R[2]), 32'd11);
        issue(3'd3, 3'd0, 3'd4, 3'd4, 2'b00, 16'h0000);
        check("Z_after_cmp_equal", 32'(Z), 32'd1);
        issue(3'd1, 3'd6, 3'd0, 3'd3, 2'b10, 16'h0000);
        issue(3'd7, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0000);
        issue(3'd6, 3'd1, 3'd1, 3'd1, 2'b11, 16'hFFFF);

        // Reset during EXEC of AND; its done must never appear
        bus.start = 1'b1; bus.opcode = 3'd4; bus.rd = 3'd5; bus.rn = 3'd2; bus.rm = 3'd1;
        bus.sh = 2'b00; bus.imm = '0;
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'($urandom);
            junk_fields();
        end
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_write_loadc_loads", 32'({bus.write, bus.loadc, bus.loads}), 32'd0);
        reset = 1'b0; bus.start = 1'b0;
        @(negedge clk);

        // Reset and start together: command dropped
        reset = 1'b1; bus.start = 1'b1; bus.opcode = 3'd0; bus.rd = 3'd7; bus.imm = 16'hFFFF;
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("reset_start_dropped", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);

        // Three legal commands after reset
        issue(3'd0, 3'd7, 3'd0, 3'd0, 2'b00, 16'h1234);
        issue(3'd5, 3'd6, 3'd0, 3'd7, 2'b01, 16'h0000);
        issue(3'd4, 3'd5, 3'd6, 3'd7, 2'b00, 16'h0000);
`ifdef DATAPATH_SEQ_OPCOUNT_EN
        check("op_count_three", 32'(bus.op_count), 32'd3);
`else
        check("op_count_three", 32'(bus.op_count), 32'd0);
`endif

        // Randomized commands, some separated by idle gaps
        for (int n = 0; n < 200; n++) begin
            issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                  2'($urandom), W'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
